// File: rtl/k12a_io_uart.sv
// k12a IO-bus UART: data/status ports, TX FIFO feeding an 8N1 serialiser, one-byte RX holding register.
// Optional internal loopback control register on port 2 when K12A_UART_LOOPBACK_EN is defined.
module k12a_io_uart #(
    parameter int         CLKS_PER_BIT  = 16,
    parameter int         TX_DEPTH_LOG2 = 2,
    parameter logic [2:0] DATA_PORT     = 3'h0,
    parameter logic [2:0] STATUS_PORT   = 3'h1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] io_addr,
    input  logic       io_load,
    input  logic       io_store,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       io_rdata_en,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam int         DEPTH    = 1 << TX_DEPTH_LOG2;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] BIT_MID  = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    logic sel_data, sel_status, sel_ctrl;
    logic data_wr, data_rd, status_rd;
    logic loopback;

    assign sel_data   = (io_addr == DATA_PORT);
    assign sel_status = (io_addr == STATUS_PORT);
    // A simultaneous store takes priority, so the load side loses its side effects.
    assign data_wr    = io_store & sel_data;
    assign data_rd    = io_load & ~io_store & sel_data;
    assign status_rd  = io_load & ~io_store & sel_status;

`ifdef K12A_UART_LOOPBACK_EN
    localparam logic [2:0] CTRL_PORT = 3'h2;

    assign sel_ctrl = (io_addr == CTRL_PORT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loopback <= 1'b0;
        end else if (io_store && sel_ctrl) begin
            loopback <= io_wdata[0];
        end
    end
`else
    assign sel_ctrl = 1'b0;
    assign loopback = 1'b0;
`endif

    // ---------------- TX FIFO ----------------
    logic [7:0]             fifo_mem [DEPTH];
    logic [TX_DEPTH_LOG2:0] wr_ptr, rd_ptr;
    logic                   fifo_empty, fifo_full, fifo_push, tx_pop;
    logic [7:0]             fifo_head;

    tx_state_t   tx_state;
    logic [15:0] tx_cnt;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_shift;
    logic        tx_line;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[TX_DEPTH_LOG2] != rd_ptr[TX_DEPTH_LOG2]) &&
                        (wr_ptr[TX_DEPTH_LOG2-1:0] == rd_ptr[TX_DEPTH_LOG2-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[TX_DEPTH_LOG2-1:0]];
    assign tx_pop     = !fifo_empty &&
                        ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == BIT_LAST));
    // A pop on the same edge frees the slot, so a write into a full FIFO still lands.
    assign fifo_push  = data_wr && (!fifo_full || tx_pop);

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr[TX_DEPTH_LOG2-1:0]] <= io_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- TX serialiser ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        tx_shift <= fifo_head;
                        tx_cnt   <= '0;
                        tx_line  <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_line  <= tx_shift[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_line  <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == BIT_LAST) begin
                        tx_cnt <= '0;
                        // Chain straight into the next start bit when more data is queued.
                        if (tx_pop) begin
                            tx_shift <= fifo_head;
                            tx_line  <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 16'd1;
                    end
                end
                default: begin
                    tx_line  <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    assign uart_tx = loopback ? 1'b1 : tx_line;

    // ---------------- RX deserialiser ----------------
    logic        rx_src, rx_sync1, rx_sync2, rx_prev;
    rx_state_t   rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_good, rx_bad;

    assign rx_src  = loopback ? tx_line : uart_rx;
    assign rx_good = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_sync2;
    assign rx_bad  = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && !rx_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= rx_src;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync2) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == BIT_MID) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync2, rx_shift[7:1]};
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync2 ? RX_IDLE : RX_WAIT;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_WAIT: begin
                    // Hold off until the line is released, so a broken frame cannot retrigger.
                    if (rx_sync2) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- RX holding register and flags ----------------
    logic [7:0] rx_data;
    logic       rx_valid, overrun, frame_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_good && (!rx_valid || data_rd)) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (data_rd) begin
                rx_valid <= 1'b0;
            end

            if (rx_good && rx_valid && !data_rd) overrun <= 1'b1;
            else if (status_rd)                  overrun <= 1'b0;

            if (rx_bad)         frame_err <= 1'b1;
            else if (status_rd) frame_err <= 1'b0;
        end
    end

    // ---------------- Read mux ----------------
    logic       tx_busy;
    logic [7:0] status;

    assign tx_busy     = !fifo_empty || (tx_state != TX_IDLE);
    assign status      = {3'b000, frame_err, overrun, rx_valid, tx_busy, fifo_full};
    assign io_rdata_en = io_load & (sel_data | sel_status | sel_ctrl);

    always_comb begin
        io_rdata = 8'h00;
        if (io_load) begin
            if (sel_data)        io_rdata = rx_data;
            else if (sel_status) io_rdata = status;
            else if (sel_ctrl)   io_rdata = {7'b0, loopback};
        end
    end

endmodule

// File: tb/tb_k12a_io_uart.sv
// Directed-plus-random bench for k12a_io_uart: bus tasks, UART line driver/monitor, frame-level RX model.
// The loopback section is compiled when K12A_UART_LOOPBACK_EN is defined.
module tb_k12a_io_uart;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] io_addr;
  logic       io_load;
  logic       io_store;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       io_rdata_en;
  logic       uart_rx;
  logic       uart_tx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // expected TX bytes, in line order
  logic [7:0] exp_q[$];

  // RX reference: holding byte plus the three status flags
  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_ferr;

  k12a_io_uart dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_addr     (io_addr),
    .io_load     (io_load),
    .io_store    (io_store),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata),
    .io_rdata_en (io_rdata_en),
    .uart_rx     (uart_rx),
    .uart_tx     (uart_tx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] frame_of(input logic [7:0] b, input logic stop_bit);
    return {stop_bit, b, 1'b0};
  endfunction

  function automatic logic [7:0] exp_status(input logic [1:0] tx_bits);
    return {3'b000, m_ferr, m_ovr, m_valid, tx_bits};
  endfunction

  // ---------------- bus driver tasks ----------------
  task automatic io_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_store = 1'b1; io_load = 1'b0;
    @(posedge clk); #1;
    io_store = 1'b0;
  endtask

  task automatic io_both(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_store = 1'b1; io_load = 1'b1;
    @(posedge clk); #1;
    io_store = 1'b0; io_load = 1'b0;
  endtask

  task automatic io_read(input logic [2:0] a, output logic [7:0] d, output logic en);
    @(negedge clk);
    io_addr = a; io_load = 1'b1; io_store = 1'b0;
    #2;
    d  = io_rdata;
    en = io_rdata_en;
    @(posedge clk); #1;
    io_load = 1'b0;
  endtask

  task automatic read_status_chk(input string tag, input logic [1:0] tx_bits);
    logic [7:0] d;
    logic       en;
    io_read(3'h1, d, en);
    check({tag, "_en"}, {15'd0, en}, 16'd1);
    check(tag, {8'd0, d}, {8'd0, exp_status(tx_bits)});
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic read_data_chk(input string tag);
    logic [7:0] d;
    logic       en;
    io_read(3'h0, d, en);
    check({tag, "_en"}, {15'd0, en}, 16'd1);
    check(tag, {8'd0, d}, {8'd0, m_data});
    m_valid = 1'b0;
  endtask

  // ---------------- UART line driver (RX side) ----------------
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = frame_of(b, stop_bit);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rx = 1'b1;
    if (stop_bit) begin
      if (m_valid) m_ovr = 1'b1;
      else begin
        m_data  = b;
        m_valid = 1'b1;
      end
    end else begin
      m_ferr = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  // ---------------- UART line monitor (TX side) ----------------
  // Samples each bit near its start (offset 1) and near its end (offset 14).
  task automatic capture_frame(output logic [9:0] early, output logic [9:0] late,
                               output int fall_cyc, output logic timed_out);
    timed_out = 1'b1;
    early = '0;
    late  = '0;
    fall_cyc = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        timed_out = 1'b0;
        break;
      end
    end
    if (!timed_out) begin
      fall_cyc = cyc;
      for (int c = 1; c <= 10 * CPB - 2; c++) begin
        @(negedge clk);
        if (c % CPB == 1)       early[c / CPB] = uart_tx;
        if (c % CPB == CPB - 2) late[c / CPB]  = uart_tx;
      end
    end
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] d;
    logic       en;
    logic [9:0] early, late;
    logic       to;
    int         fall, prev_fall, lows, accepted;
    logic [7:0] b;

    rst_n = 1'b0; io_addr = 3'h0; io_load = 1'b0; io_store = 1'b0; io_wdata = 8'h00; uart_rx = 1'b1;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {15'd0, uart_tx}, 16'd1);
    check("rst_rdata_en", {15'd0, io_rdata_en}, 16'd0);
    check("rst_rdata", {8'd0, io_rdata}, 16'd0);
    rst_n = 1'b1;
    read_status_chk("rst_status", 2'b00);
    read_data_chk("rst_data");

    // unmapped ports stay off the bus
    io_read(3'h5, d, en);
    check("unmapped5_en", {15'd0, en}, 16'd0);
    io_read(3'h2, d, en);
`ifdef K12A_UART_LOOPBACK_EN
    check("port2_en", {15'd0, en}, 16'd1);
`else
    check("port2_en", {15'd0, en}, 16'd0);
`endif

    // single frame 8'hA5 with exact bit timing
    io_write(3'h0, 8'hA5);
    read_status_chk("a5_busy_pre", 2'b10);
    fork
      capture_frame(early, late, fall, to);
      begin
        repeat (80) @(negedge clk);
        read_status_chk("a5_busy_mid", 2'b10);
      end
    join
    check("a5_timeout", {15'd0, to}, 16'd0);
    check("a5_early", {6'd0, early}, {6'd0, frame_of(8'hA5, 1'b1)});
    check("a5_late", {6'd0, late}, {6'd0, frame_of(8'hA5, 1'b1)});
    repeat (20) @(negedge clk);
    read_status_chk("a5_idle", 2'b00);

    // burst of 6 random writes: shifter + FIFO hold DEPTH+1, the sixth is dropped
    accepted = 0;
    prev_fall = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          b = 8'($urandom_range(0, 255));
          io_write(3'h0, b);
          if (accepted < DEPTH + 1) begin
            exp_q.push_back(b);
            accepted++;
          end
        end
        read_status_chk("burst_full", 2'b11);
      end
      begin
        for (int f = 0; f < DEPTH + 1; f++) begin
          capture_frame(early, late, fall, to);
          check("burst_timeout", {15'd0, to}, 16'd0);
          if (exp_q.size() > 0) b = exp_q.pop_front();
          else b = 8'hxx;
          check("burst_early", {6'd0, early}, {6'd0, frame_of(b, 1'b1)});
          check("burst_late", {6'd0, late}, {6'd0, frame_of(b, 1'b1)});
          if (f > 0) check("burst_gap", 16'(fall - prev_fall), 16'(10 * CPB));
          prev_fall = fall;
        end
      end
    join
    check("burst_q_left", 16'(exp_q.size()), 16'd0);
    count_low(12 * CPB, lows);
    check("burst_no_extra", 16'(lows), 16'd0);
    read_status_chk("burst_idle", 2'b00);

    // RX 8'h3C; a load+store collision pushes TX and leaves rx_valid alone
    drive_frame(8'h3C, 1'b1);
    read_status_chk("rx3c_status", 2'b00);
    io_both(3'h0, 8'h66);
    capture_frame(early, late, fall, to);
    check("both_timeout", {15'd0, to}, 16'd0);
    check("both_frame", {6'd0, early}, {6'd0, frame_of(8'h66, 1'b1)});
    repeat (10) @(negedge clk);
    read_status_chk("both_status", 2'b00);
    read_data_chk("rx3c_data");
    read_status_chk("rx3c_after", 2'b00);

    // overrun: two frames, no read between
    drive_frame(8'h81, 1'b1);
    drive_frame(8'h7E, 1'b1);
    read_status_chk("ovr_status", 2'b00);
    read_status_chk("ovr_cleared", 2'b00);
    read_data_chk("ovr_data");
    read_data_chk("ovr_stale");

    // framing error then short glitch
    drive_frame(8'hC3, 1'b0);
    @(negedge clk); uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    read_status_chk("ferr_status", 2'b00);
    read_status_chk("ferr_cleared", 2'b00);
    read_data_chk("ferr_stale");

    // random RX traffic with random read order
    for (int it = 0; it < 5; it++) begin
      int nf;
      nf = $urandom_range(1, 2);
      for (int f = 0; f < nf; f++) begin
        b = 8'($urandom_range(0, 255));
        drive_frame(b, ($urandom_range(0, 3) != 0));
      end
      if ($urandom_range(0, 1) == 1) begin
        read_status_chk("rnd_status", 2'b00);
        read_data_chk("rnd_data");
      end else begin
        read_data_chk("rnd_data");
        read_status_chk("rnd_status", 2'b00);
      end
    end

`ifdef K12A_UART_LOOPBACK_EN
    io_write(3'h2, 8'h01);
    io_read(3'h2, d, en);
    check("lb_ctrl", {8'd0, d}, 16'h0001);
    io_write(3'h0, 8'h5A);
    count_low(12 * CPB, lows);
    check("lb_tx_high", 16'(lows), 16'd0);
    if (m_valid) m_ovr = 1'b1;
    else begin
      m_data  = 8'h5A;
      m_valid = 1'b1;
    end
    read_status_chk("lb_status", 2'b00);
    read_data_chk("lb_data");
    io_write(3'h2, 8'h00);
`endif

    // reset in the middle of a frame drops the line high at once
    io_write(3'h0, 8'h00);
    to = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        to = 1'b0;
        break;
      end
    end
    check("midrst_fall", {15'd0, to}, 16'd0);
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", {15'd0, uart_tx}, 16'd1);
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_low(12 * CPB, lows);
    check("midrst_quiet", 16'(lows), 16'd0);
    read_status_chk("midrst_status", 2'b00);
    read_data_chk("midrst_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/k12a_io_uart.md
Name: k12a_io_uart

Overview:
- CPU-side I/O port responder for the k12a IO bus (`io_load`/`io_store`, 3-bit port number from `inst[2:0]`, 8-bit data bus).
- Answers CPU `in`/`out` instructions.
- Serialises written bytes onto an 8N1 UART line through a small TX FIFO.
- Deserialises incoming line traffic into a one-byte RX holding register with status flags.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 4..65535.
- TX_DEPTH_LOG2, 2, log2 of TX FIFO depth (default depth 4).
- DATA_PORT, 3'h0, port number for data: write pushes TX, read pops RX.
- STATUS_PORT, 3'h1, port number for the read-only status register.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- io_addr  in  3  port number (CPU `inst[2:0]`).
- io_load  in  1  CPU reads port this cycle (`in` instruction).
- io_store  in  1  CPU writes port this cycle (`out` instruction).
- io_wdata  in  8  data bus value during `io_store`.
- io_rdata  out  8  read data, combinational from registered state.
- io_rdata_en  out  1  high when this block drives the data bus (`io_load` and address matches).
- uart_rx  in  1  serial input, asynchronous, idle high.
- uart_tx  out  1  serial output, idle high.

Behaviour:
- Reset values:
  - `uart_tx`=1; FIFO empty; TX FSM IDLE; RX FSM IDLE.
  - rx_valid=0, overrun=0, frame_err=0, rx_data=0.
  - `io_rdata`=0, `io_rdata_en`=0.
- Bus timing:
  - Reads are same-cycle: CPU latches `io_rdata` at the EXEC clock edge.
  - Side effects of reads and writes take effect on that same edge.
  - `io_load` and `io_store` are never asserted together; if they are, `io_store` wins and the read has no side effect.
  - Unmatched port numbers: no response, `io_rdata_en`=0.
- DATA_PORT write:
  - Pushes `io_wdata` into the FIFO.
  - If the FIFO is full, the byte is dropped and no state changes.
- DATA_PORT read:
  - Returns rx_data, then clears rx_valid.
  - If rx_valid=0, returns the stale rx_data with no side effect.
- STATUS_PORT read returns:
  - {3'b0, frame_err, overrun, rx_valid, tx_busy, tx_full}.
  - tx_busy = FIFO non-empty OR TX FSM not IDLE.
  - Clears overrun and frame_err on the same edge (clear-on-read).
  - If a new error sets on that same edge, set wins.
- STATUS_PORT write: ignored.
- TX FSM (IDLE -> START -> DATA -> STOP -> IDLE):
  - Bit counter runs 0..CLKS_PER_BIT-1; each phase lasts exactly CLKS_PER_BIT cycles.
  - IDLE with FIFO non-empty: pop the head into the shift register, go to START; `uart_tx` falls on the next edge.
  - DATA: LSB first, 8 bits.
  - STOP: line high.
  - STOP -> START directly when the FIFO is non-empty (back-to-back frames, no idle gap).
  - FIFO full and FSM pop on the same edge: the push succeeds.
- FIFO:
  - Circular, read and write pointers are TX_DEPTH_LOG2+1 bits wide.
  - full = pointers differ only in MSB; empty = pointers equal; wrap is natural.
- RX:
  - `uart_rx` passes a 2-flop synchroniser.
  - IDLE detects the falling edge of the synchronised input, then goes to START.
  - START re-samples at CLKS_PER_BIT/2:
    - if high (glitch), return to IDLE;
    - else go to DATA and sample each bit at the mid-point, LSB first;
    - then go to STOP and sample at the mid-point.
  - Stop bit sampled low: set frame_err, discard the byte, wait for the line to go high before returning to IDLE.
  - Good stop bit:
    - if rx_valid is already 1, set overrun and keep the old byte;
    - else load rx_data and set rx_valid.
  - CPU pop and new byte arrival on the same edge: the new byte is loaded, rx_valid stays 1, no overrun.
- Reset mid-frame: line returns high immediately; the partial frame is lost.

Optional Feature:
- Macro K12A_UART_LOOPBACK_EN.
- When defined:
  - Port 3'h2 becomes a read/write control register; bit0 = loopback, reset 0.
  - With loopback=1, the RX synchroniser input is the internal TX serial signal instead of `uart_rx`.
  - With loopback=1, `uart_tx` is held at 1.
  - Reads of port 2 return {7'b0, loopback}.
- When undefined: port 2 is unmapped (`io_rdata_en`=0), and RX always uses `uart_rx`.

Test Plan:
- Reset, then write 8'hA5 to port 0 with CLKS_PER_BIT=16 -> `uart_tx` low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high; status bit1 reads 1 during the frame and 0 after.
- Write 5 bytes back-to-back, depth 4, TX idle -> first byte pops immediately, so all 5 are accepted; 6th write while full is dropped; frames are contiguous with no idle gap between stop and start.
- Drive an 8'h3C frame on `uart_rx` -> status reads 8'h04; port 0 read returns 8'h3C; next status read returns 8'h00.
- Two frames with no intervening read -> status reads 8'h0C and rx_data is the first byte; a second status read shows overrun cleared (8'h04).
- Frame with stop bit low, then a 3-cycle low glitch -> frame_err set (status 8'h10), no rx_valid; the glitch produces no byte.
- (K12A_UART_LOOPBACK_EN) write 8'h01 to port 2, then 8'h5A to port 0 -> `uart_tx` stays high, and after about 10 bit times port 0 reads 8'h5A.
